// File: rtl/led_bias_pkg.sv
// Shared types and default constants for the LED bias sequencer.
// The channel state enum is shared by the sequencer top, the channel FSM
// and the testbench.
package led_bias_pkg;

   typedef enum logic [2:0] {
      OFF      = 3'd0,
      WAIT_REF = 3'd1,
      SETTLE   = 3'd2,
      READY    = 3'd3,
      DRAIN    = 3'd4
   } led_bias_state_e;

   localparam int DEF_SETTLE_CYCLES  = 64;
   localparam int DEF_DRAIN_CYCLES   = 16;
   localparam int DEF_TIMEOUT_CYCLES = 200;
   localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/led_bias_sequencer_if.sv
// Signal bundle between the fabric/bias-block side and the LED bias sequencer.
// The master modport is the sequencer itself; the slave modport is the
// environment that issues requests and reports reference status.
interface led_bias_sequencer_if;

   logic       poc;
   logic       icc40u;
   logic       ir_req;
   logic       rgb_req;
   logic       ir_vref_in;
   logic       rgb_vref_in;
   logic       irled_en;
   logic       rgbled_en;
   logic       ir_drv_en;
   logic       rgb_drv_en;
   logic       ir_ready;
   logic       rgb_ready;
   logic [1:0] fault;

   modport master (
      input  poc, icc40u, ir_req, rgb_req, ir_vref_in, rgb_vref_in,
      output irled_en, rgbled_en, ir_drv_en, rgb_drv_en, ir_ready, rgb_ready, fault
   );

   modport slave (
      output poc, icc40u, ir_req, rgb_req, ir_vref_in, rgb_vref_in,
      input  irled_en, rgbled_en, ir_drv_en, rgb_drv_en, ir_ready, rgb_ready, fault
   );

endinterface

// File: rtl/led_bias_chan_fsm.sv
// One LED bias channel: vref synchronizer, private counter and the
// OFF/WAIT_REF/SETTLE/READY/DRAIN sequencer with registered outputs.
// Optional build macro LED_BIAS_TIMEOUT_EN adds a sticky wait-for-vref
// timeout fault; without it WAIT_REF waits forever and fault_o is 0.
module led_bias_chan_fsm
   import led_bias_pkg::*;
#(
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic poc_i,
   input  logic icc40u_i,
   input  logic req_i,
   input  logic vref_i,
   output logic biasEn_o,
   output logic drvEn_o,
   output logic ready_o,
   output logic fault_o
);

   // The edge that first sees the synced reference counts as the first
   // settle cycle, so SETTLE itself is loaded two short of the total.
   localparam bit              SETTLE_SKIP = (SETTLE_CYCLES <= 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = SETTLE_SKIP ? '0 : CNT_W'(SETTLE_CYCLES - 2);
   localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);

   led_bias_state_e   state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              vrefMeta_q;
   logic              vrefSync_q;
   logic              biasEn_q;
   logic              drvEn_q;
   logic              reqEff;
   logic              faultBlock;

   // Low-current mode looks exactly like a dropped request to the FSM.
   assign reqEff = req_i & ~icc40u_i;

`ifdef LED_BIAS_TIMEOUT_EN
   logic fault_q;
   assign faultBlock = fault_q;
   assign fault_o    = fault_q;
`else
   assign faultBlock = 1'b0;
   assign fault_o    = 1'b0;
`endif

   // Two-flop synchronizer for the analog reference status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vrefMeta_q <= 1'b0;
         vrefSync_q <= 1'b0;
      end else begin
         vrefMeta_q <= vref_i;
         vrefSync_q <= vrefMeta_q;
      end
   end

   // Channel sequencer; outputs are written together with the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= OFF;
         cnt_q    <= '0;
         biasEn_q <= 1'b0;
         drvEn_q  <= 1'b0;
`ifdef LED_BIAS_TIMEOUT_EN
         fault_q  <= 1'b0;
`endif
      end else if (poc_i) begin
         state_q  <= OFF;
         cnt_q    <= '0;
         biasEn_q <= 1'b0;
         drvEn_q  <= 1'b0;
`ifdef LED_BIAS_TIMEOUT_EN
         fault_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            OFF: begin
               if (reqEff && !faultBlock) begin
                  state_q  <= WAIT_REF;
                  cnt_q    <= WAIT_LOAD;
                  biasEn_q <= 1'b1;
               end
            end
            WAIT_REF: begin
               if (!reqEff) begin
                  state_q <= DRAIN;
                  cnt_q   <= DRAIN_LOAD;
               end else if (vrefSync_q) begin
                  if (SETTLE_SKIP) begin
                     state_q <= READY;
                     cnt_q   <= '0;
                     drvEn_q <= 1'b1;
                  end else begin
                     state_q <= SETTLE;
                     cnt_q   <= SETTLE_LOAD;
                  end
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
`ifdef LED_BIAS_TIMEOUT_EN
               else begin
                  state_q <= DRAIN;
                  cnt_q   <= DRAIN_LOAD;
                  fault_q <= 1'b1;
               end
`endif
            end
            SETTLE: begin
               if (!reqEff) begin
                  state_q <= DRAIN;
                  cnt_q   <= DRAIN_LOAD;
               end else if (!vrefSync_q) begin
                  state_q <= WAIT_REF;
                  cnt_q   <= WAIT_LOAD;
               end else if (cnt_q == '0) begin
                  state_q <= READY;
                  drvEn_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            READY: begin
               if (!reqEff) begin
                  state_q <= DRAIN;
                  cnt_q   <= DRAIN_LOAD;
                  drvEn_q <= 1'b0;
               end else if (!vrefSync_q) begin
                  state_q <= WAIT_REF;
                  cnt_q   <= WAIT_LOAD;
                  drvEn_q <= 1'b0;
               end
            end
            DRAIN: begin
               if (cnt_q == '0) begin
                  state_q  <= OFF;
                  biasEn_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q  <= OFF;
               cnt_q    <= '0;
               biasEn_q <= 1'b0;
               drvEn_q  <= 1'b0;
            end
         endcase
      end
   end

   assign biasEn_o = biasEn_q;
   assign drvEn_o  = drvEn_q;
   assign ready_o  = drvEn_q;

endmodule

// File: rtl/led_bias_sequencer.sv
// LED bias sequencer top: two independent channel FSMs (IR and RGB) that
// drive the bias-block enables and the PWM driver enables.
// Optional build macro LED_BIAS_TIMEOUT_EN enables the per-channel
// wait-for-vref timeout and its sticky fault bits.
module led_bias_sequencer
   import led_bias_pkg::*;
#(
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   led_bias_sequencer_if.master bus
);

   logic irFault;
   logic rgbFault;

   led_bias_chan_fsm #(
      .SETTLE_CYCLES  (SETTLE_CYCLES),
      .DRAIN_CYCLES   (DRAIN_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) uIrChan (
      .clk      (clk),
      .rst_n    (rst_n),
      .poc_i    (bus.poc),
      .icc40u_i (bus.icc40u),
      .req_i    (bus.ir_req),
      .vref_i   (bus.ir_vref_in),
      .biasEn_o (bus.irled_en),
      .drvEn_o  (bus.ir_drv_en),
      .ready_o  (bus.ir_ready),
      .fault_o  (irFault)
   );

   led_bias_chan_fsm #(
      .SETTLE_CYCLES  (SETTLE_CYCLES),
      .DRAIN_CYCLES   (DRAIN_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) uRgbChan (
      .clk      (clk),
      .rst_n    (rst_n),
      .poc_i    (bus.poc),
      .icc40u_i (bus.icc40u),
      .req_i    (bus.rgb_req),
      .vref_i   (bus.rgb_vref_in),
      .biasEn_o (bus.rgbled_en),
      .drvEn_o  (bus.rgb_drv_en),
      .ready_o  (bus.rgb_ready),
      .fault_o  (rgbFault)
   );

   assign bus.fault = {rgbFault, irFault};

endmodule

// File: tb/tb_led_bias_sequencer.sv
// Directed testbench for led_bias_sequencer with SETTLE=4, DRAIN=3, TIMEOUT=10.
// The bias block is modelled as vref following its enable one cycle later,
// gated by a per-channel "reference healthy" flag.
// Timeout checks run when LED_BIAS_TIMEOUT_EN is defined.
module tb_led_bias_sequencer;
   import led_bias_pkg::*;

   localparam int TB_SETTLE  = 4;
   localparam int TB_DRAIN   = 3;
   localparam int TB_TIMEOUT = 10;
   localparam int TB_CNT_W   = 8;

   logic clk;
   logic rst_n;
   led_bias_sequencer_if bus();

   int   checkCount = 0;
   int   passCount  = 0;
   int   failCount  = 0;
   logic irVrefOk   = 1'b1;
   logic rgbVrefOk  = 1'b1;
   logic irLedPrev  = 1'b0;
   logic rgbLedPrev = 1'b0;

   led_bias_sequencer #(
      .SETTLE_CYCLES  (TB_SETTLE),
      .DRAIN_CYCLES   (TB_DRAIN),
      .CNT_W          (TB_CNT_W),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view of every output: {irled, rgbled, irdrv, rgbdrv, irrdy, rgbrdy, fault[1:0]}.
   function automatic logic [7:0] outVec();
      return {bus.irled_en, bus.rgbled_en, bus.ir_drv_en, bus.rgb_drv_en,
              bus.ir_ready, bus.rgb_ready, bus.fault};
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic irReq, input logic rgbReq, input logic icc, input logic pocIn);
      bus.ir_req  = irReq;
      bus.rgb_req = rgbReq;
      bus.icc40u  = icc;
      bus.poc     = pocIn;
   endtask

   // One clock; sample 1 unit after the edge and update the bias-block model.
   task automatic tick();
      @(posedge clk);
      #1;
      bus.ir_vref_in  = irLedPrev & irVrefOk;
      bus.rgb_vref_in = rgbLedPrev & rgbVrefOk;
      irLedPrev       = bus.irled_en;
      rgbLedPrev      = bus.rgbled_en;
   endtask

   task automatic waitTicks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      bus.ir_vref_in  = 1'b0;
      bus.rgb_vref_in = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset_outputs", outVec(), 8'h00);
      checkOutput("reset_ir_state", 8'(dut.uIrChan.state_q), 8'(OFF));
      checkOutput("reset_rgb_cnt", 8'(dut.uRgbChan.cnt_q), 8'h00);
      waitTicks(2);
      rst_n = 1'b1;
      tick();
      checkOutput("post_reset_idle", outVec(), 8'h00);

      $display("[TB] basic IR sequence");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("ir_bias_one_cycle", 8'(bus.irled_en), 8'h01);
      checkOutput("ir_not_ready_yet", 8'(bus.ir_ready), 8'h00);
      waitTicks(6);
      checkOutput("ir_ready_not_early", 8'(bus.ir_ready), 8'h00);
      tick();
      checkOutput("ir_ready_latency", 8'(bus.ir_ready), 8'h01);
      checkOutput("ir_drv_en_ready", 8'(bus.ir_drv_en), 8'h01);
      checkOutput("rgb_quiet_fault_zero", {bus.rgbled_en, bus.rgb_drv_en, bus.rgb_ready, 3'b000, bus.fault}, 8'h00);

      $display("[TB] IR release and drain");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("ir_drv_off_on_release", {bus.irled_en, bus.ir_drv_en, bus.ir_ready}, 8'h04);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("ir_drain_bias_c2", 8'(bus.irled_en), 8'h01);
      tick();
      checkOutput("ir_drain_state_c3", 8'(dut.uIrChan.state_q), 8'(DRAIN));
      tick();
      checkOutput("ir_bias_off_after_drain", 8'(bus.irled_en), 8'h00);
      checkOutput("ir_off_despite_req", 8'(dut.uIrChan.state_q), 8'(OFF));
      tick();
      checkOutput("ir_reraise_after_off", 8'(dut.uIrChan.state_q), 8'(WAIT_REF));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("ir_wait_drop_to_drain", 8'(dut.uIrChan.state_q), 8'(DRAIN));
      waitTicks(3);
      checkOutput("ir_idle_again", 8'(bus.irled_en), 8'h00);
      waitTicks(5);

      $display("[TB] icc40u handling");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      waitTicks(3);
      checkOutput("icc_blocks_rgb_bias", 8'(bus.rgbled_en), 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("rgb_bias_after_icc_release", 8'(bus.rgbled_en), 8'h01);
      waitTicks(6);
      checkOutput("rgb_ready_not_early", 8'(bus.rgb_ready), 8'h00);
      tick();
      checkOutput("rgb_ready_latency", 8'(bus.rgb_ready), 8'h01);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("icc_drain", {bus.rgbled_en, bus.rgb_drv_en, 3'b000, 3'(dut.uRgbChan.state_q)}, {1'b1, 1'b0, 3'b000, 3'(DRAIN)});
      waitTicks(3);
      checkOutput("icc_off", {bus.rgbled_en, 4'b0000, 3'(dut.uRgbChan.state_q)}, {1'b0, 4'b0000, 3'(OFF)});
      waitTicks(5);
      checkOutput("icc_holds_off", 8'(bus.rgbled_en), 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      waitTicks(8);
      checkOutput("rgb_ready_again", 8'(bus.rgb_ready), 8'h01);

      $display("[TB] RGB vref loss");
      rgbVrefOk       = 1'b0;
      bus.rgb_vref_in = 1'b0;
      waitTicks(2);
      checkOutput("rgb_ready_holds_during_sync", 8'(bus.rgb_ready), 8'h01);
      tick();
      checkOutput("rgb_vref_loss_outputs", {bus.rgbled_en, bus.rgb_drv_en, bus.rgb_ready}, 8'h04);
      checkOutput("rgb_vref_loss_state", 8'(dut.uRgbChan.state_q), 8'(WAIT_REF));
      rgbVrefOk       = 1'b1;
      bus.rgb_vref_in = 1'b1;
      waitTicks(5);
      checkOutput("rgb_recover_not_early", 8'(bus.rgb_ready), 8'h00);
      tick();
      checkOutput("rgb_recover_ready", 8'(bus.rgb_ready), 8'h01);
      checkOutput("fault_zero_after_loss", 8'(bus.fault), 8'h00);

      $display("[TB] poc with both channels settling");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      waitTicks(10);
      checkOutput("both_idle_before_poc", outVec(), 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      waitTicks(6);
      checkOutput("both_in_settle", {2'b00, 3'(dut.uIrChan.state_q), 3'(dut.uRgbChan.state_q)}, {2'b00, 3'(SETTLE), 3'(SETTLE)});
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("poc_all_outputs_zero", outVec(), 8'h00);
      checkOutput("poc_states_off", {2'b00, 3'(dut.uIrChan.state_q), 3'(dut.uRgbChan.state_q)}, {2'b00, 3'(OFF), 3'(OFF)});
      checkOutput("poc_cnt_cleared", dut.uIrChan.cnt_q | dut.uRgbChan.cnt_q, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      waitTicks(5);
      checkOutput("idle_after_poc", outVec(), 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      waitTicks(7);
      checkOutput("restart_not_early", {6'b000000, bus.ir_ready, bus.rgb_ready}, 8'h00);
      tick();
      checkOutput("poc_restart_ready", {6'b000000, bus.ir_ready, bus.rgb_ready}, 8'h03);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      waitTicks(10);

`ifdef LED_BIAS_TIMEOUT_EN
      $display("[TB] IR vref timeout");
      irVrefOk = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("timeout_enter_wait", 8'(dut.uIrChan.state_q), 8'(WAIT_REF));
      waitTicks(9);
      checkOutput("timeout_not_early", {3'b000, 3'(dut.uIrChan.state_q), bus.fault}, {3'b000, 3'(WAIT_REF), 2'b00});
      tick();
      checkOutput("timeout_fault_set", {3'b000, 3'(dut.uIrChan.state_q), bus.fault}, {3'b000, 3'(DRAIN), 2'b01});
      waitTicks(6);
      checkOutput("fault_holds_off", {2'b00, bus.irled_en, 3'(dut.uIrChan.state_q), bus.fault}, {2'b00, 1'b0, 3'(OFF), 2'b01});
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("poc_clears_fault", 8'(bus.fault), 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("ir_rearm_after_poc", 8'(bus.irled_en), 8'h01);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      waitTicks(6);
      irVrefOk = 1'b1;
`else
      $display("[TB] IR waits without timeout");
      irVrefOk = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      waitTicks(15);
      checkOutput("no_timeout_still_waiting", {3'b000, 3'(dut.uIrChan.state_q), bus.fault}, {3'b000, 3'(WAIT_REF), 2'b00});
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      waitTicks(6);
      checkOutput("no_timeout_drained", 8'(bus.irled_en), 8'h00);
      irVrefOk = 1'b1;
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
